// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate extender with a 2-entry result queue (optional EXT_ERR_EN adds out_err/err_cnt)
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_eop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef EXT_ERR_EN
  ,
  output logic             out_err,
  output logic [7:0]       err_cnt
`endif
);
  logic [OUT_W-1:0] sext, zext, ext, last_data;
  logic [OUT_W-1:0] data_mem [2];
  logic [TAG_W-1:0] tag_mem [2];
  logic [TAG_W-1:0] last_tag;
  logic [1:0]       count;
  logic             wptr, rptr, push, pop, rsvd;

  assign in_ready  = (count != 2'd2) & reset_n;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign rsvd      = (in_eop >= 3'd5);
  assign out_data  = out_valid ? data_mem[rptr] : last_data;
  assign out_tag   = out_valid ? tag_mem[rptr] : last_tag;

  // extension of the incoming immediate; reserved ops give zero
  always_comb begin
    sext = OUT_W'($signed(in_imm));
    zext = OUT_W'(in_imm);
    ext  = in_eop == 3'd0 ? sext :
           in_eop == 3'd1 ? zext :
           in_eop == 3'd2 ? zext << (OUT_W - IN_W) :
           in_eop == 3'd3 ? sext << SHIFT :
           in_eop == 3'd4 ? zext << SHIFT : '0;
  end

  // queue storage, written only on a real push so idle-input X never lands in state
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wptr] <= ext;
      tag_mem[wptr]  <= in_tag;
    end
  end

  // pointers, occupancy and last-popped holding registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      last_data <= '0;
      last_tag  <= '0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop) begin
        rptr      <= ~rptr;
        last_data <= data_mem[rptr];
        last_tag  <= tag_mem[rptr];
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

`ifdef EXT_ERR_EN
  logic err_mem [2];

  assign out_err = out_valid & err_mem[rptr];

  // per-entry reserved-op flag travels with its result
  always_ff @(posedge clk) begin
    if (push) err_mem[wptr] <= rsvd;
  end

  // saturating count of accepted reserved-op requests
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_cnt <= '0;
    else if (push && rsvd && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  logic unused_rsvd;
  assign unused_rsvd = rsvd;
`endif
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe (define EXT_ERR_EN to cover the error option)
module tb_ext_pipe;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_eop;
  logic [4:0]  in_tag;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
`ifdef EXT_ERR_EN
  logic        out_err;
  logic [7:0]  err_cnt;
  wire  [37:0] act = {out_err, out_data, out_tag};
  localparam bit ERR = 1'b1;
`else
  wire  [37:0] act = {1'b0, out_data, out_tag};
  localparam bit ERR = 1'b0;
`endif

  ext_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_eop(in_eop), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef EXT_ERR_EN
    , .out_err(out_err), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n = 0, fails = 0;
  logic [37:0] q[$];
  logic [37:0] last;
  logic [15:0] imms [8] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'hC000, 16'h7FFF, 16'h1234, 16'hABCD};
  logic [2:0]  eops [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd5, 3'd7};

  function automatic logic [37:0] model(logic [15:0] imm, logic [2:0] eop, logic [4:0] tag);
    logic [31:0] s, z, d;
    s = {{16{imm[15]}}, imm};
    z = {16'h0000, imm};
    case (eop)
      3'd0: d = s;
      3'd1: d = z;
      3'd2: d = {imm, 16'h0000};
      3'd3: d = {s[29:0], 2'b00};
      3'd4: d = {z[29:0], 2'b00};
      default: d = 32'h0;
    endcase
    return {ERR && eop >= 3'd5, d, tag};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_imm = '0; in_eop = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    n++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_hold: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || act !== 38'h0) begin
      fails++; $display("FAIL reset_state: out_valid=%b in_ready=%b out=%h, required 0 1 0", out_valid, in_ready, act);
    end
`ifdef EXT_ERR_EN
    n++;
    if (err_cnt !== 8'h00) begin fails++; $display("FAIL reset_err_cnt: got %h, required 00", err_cnt); end
`endif
    q.delete(); last = '0;
  endtask

  task automatic test_ops();
    logic v, r; logic [15:0] imm; logic [2:0] eop; logic [4:0] tag; int sz;
    for (int i = 0; i < 42; i++) begin
      if (i < 8) begin v = 1'b1; r = 1'b1; imm = imms[i]; eop = eops[i]; end
      else if (i < 38) begin v = 1'($urandom); r = 1'($urandom); imm = 16'($urandom); eop = 3'($urandom); end
      else begin v = 1'b0; r = 1'b1; imm = '0; eop = '0; end
      tag = 5'(i);
      @(negedge clk);
      out_ready = r; sz = q.size();
      n++;
      if (out_valid !== (sz != 0) || in_ready !== (sz != 2)) begin
        fails++; $display("FAIL ops_flags cyc %0d: out_valid=%b in_ready=%b, required %b %b", i, out_valid, in_ready, sz != 0, sz != 2);
      end
      if (sz != 0) begin
        n++;
        if (act !== q[0]) begin fails++; $display("FAIL ops_data cyc %0d: got %h, required %h", i, act, q[0]); end
        if (r) last = q.pop_front();
      end
      in_valid = v; in_imm = v ? imm : 'x; in_eop = eop; in_tag = tag;
      if (v && sz != 2) q.push_back(model(imm, eop, tag));
    end
    @(negedge clk);
    n++;
    if (out_valid !== 1'b0 || act !== {1'b0, last[36:0]}) begin
      fails++; $display("FAIL ops_hold_last: out_valid=%b out=%h, required 0 %h", out_valid, act, {1'b0, last[36:0]});
    end
  endtask

  task automatic test_backpressure();
    logic v, r; int sz;
    for (int i = 0; i < 8; i++) begin
      v = (i < 4); r = (i >= 4);
      @(negedge clk);
      out_ready = r; sz = q.size();
      n++;
      if (out_valid !== (sz != 0) || in_ready !== (sz != 2)) begin
        fails++; $display("FAIL bp_flags cyc %0d: out_valid=%b in_ready=%b, required %b %b", i, out_valid, in_ready, sz != 0, sz != 2);
      end
      if (i == 2 || i == 3 || i == 6) begin
        n++;
        if (in_ready !== (i == 6)) begin fails++; $display("FAIL bp_in_ready cyc %0d: got %b, required %b", i, in_ready, i == 6); end
      end
      if (sz != 0) begin
        n++;
        if (act !== q[0]) begin fails++; $display("FAIL bp_data cyc %0d: got %h, required %h", i, act, q[0]); end
        if (r) last = q.pop_front();
      end
      in_valid = v; in_imm = 16'h0100 + 16'(i); in_eop = 3'd1; in_tag = 5'(i + 1);
      if (v && sz != 2) q.push_back(model(in_imm, in_eop, in_tag));
    end
  endtask

  task automatic test_back_to_back();
    logic v; int sz;
    for (int i = 0; i < 14; i++) begin
      v = (i < 11);
      @(negedge clk);
      out_ready = 1'b1; sz = q.size();
      n++;
      if (out_valid !== (sz != 0) || in_ready !== (sz != 2) || (i >= 1 && i <= 11 && out_valid !== 1'b1)) begin
        fails++; $display("FAIL b2b_flags cyc %0d: out_valid=%b in_ready=%b, required %b %b", i, out_valid, in_ready, sz != 0, sz != 2);
      end
      if (sz != 0) begin
        n++;
        if (act !== q[0]) begin fails++; $display("FAIL b2b_data cyc %0d: got %h, required %h", i, act, q[0]); end
        last = q.pop_front();
      end
      in_valid = v; in_imm = 16'hF000 ^ 16'(i * 37); in_eop = 3'(i % 5); in_tag = 5'(i + 10);
      if (v && sz != 2) q.push_back(model(in_imm, in_eop, in_tag));
    end
  endtask

  task automatic test_reset_mid();
    int sz;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_imm = 16'h5555 + 16'(i); in_eop = 3'd0; in_tag = 5'(20 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n++;
    if (out_valid !== 1'b0 || act !== 38'h0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL rst_mid_clear: out_valid=%b out=%h in_ready=%b, required 0 0 0", out_valid, act, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    q.delete(); last = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1; sz = q.size();
      n++;
      if (out_valid !== (sz != 0) || in_ready !== (sz != 2)) begin
        fails++; $display("FAIL rst_mid_flags cyc %0d: out_valid=%b in_ready=%b, required %b %b", i, out_valid, in_ready, sz != 0, sz != 2);
      end
      if (sz != 0) begin
        n++;
        if (act !== q[0]) begin fails++; $display("FAIL rst_mid_data cyc %0d: got %h, required %h", i, act, q[0]); end
        last = q.pop_front();
      end
      in_valid = (i == 0); in_imm = 16'h0042; in_eop = 3'd1; in_tag = 5'd7;
      if (in_valid && sz != 2) q.push_back(model(in_imm, in_eop, in_tag));
    end
  endtask

`ifdef EXT_ERR_EN
  task automatic test_err();
    int sz;
    for (int i = 0; i < 306; i++) begin
      @(negedge clk);
      out_ready = 1'b1; sz = q.size();
      if (i == 4 || i == 305) begin
        n++;
        if (err_cnt !== (i == 4 ? 8'd3 : 8'hFF)) begin
          fails++; $display("FAIL err_cnt cyc %0d: got %h, required %h", i, err_cnt, i == 4 ? 8'd3 : 8'hFF);
        end
      end
      n++;
      if (out_valid !== (sz != 0) || in_ready !== (sz != 2)) begin
        fails++; $display("FAIL err_flags cyc %0d: out_valid=%b in_ready=%b, required %b %b", i, out_valid, in_ready, sz != 0, sz != 2);
      end
      if (sz != 0) begin
        n++;
        if (act !== q[0]) begin fails++; $display("FAIL err_data cyc %0d: got %h, required %h", i, act, q[0]); end
        last = q.pop_front();
      end
      in_valid = (i < 3) || (i >= 5 && i < 303);
      in_imm = 16'($urandom); in_eop = i < 3 ? 3'd5 : 3'($urandom_range(5, 7)); in_tag = 5'(i);
      if (in_valid && sz != 2) q.push_back(model(in_imm, in_eop, in_tag));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef EXT_ERR_EN
    test_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
